// File: rtl/tenyr_pkg.sv
// rtl/tenyr_pkg.sv - shared widths, fetch state encoding and PC helper for the tenyr core
package tenyr_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 24'h000000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  // Sequential fetch address; natural 24-bit wrap from FFFFFF to 000000.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + 24'd1;
  endfunction

endpackage

// File: rtl/tenyr_lat_cnt.sv
// rtl/tenyr_lat_cnt.sv - 4-bit load/decrement counter with zero flag for memory latency
module tenyr_lat_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic       dec_i,
  input  logic [3:0] load_val_i,
  output logic       zero_o
);

  logic [3:0] count_q;

  // Load has priority over decrement; decrement saturates at zero.
  always_ff @(negedge clk) begin
    if (reset) begin
      count_q <= 4'd0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != 4'd0)) begin
      count_q <= count_q - 4'd1;
    end
  end

  assign zero_o = (count_q == 4'd0);

endmodule

// File: rtl/tenyr_fetch.sv
// rtl/tenyr_fetch.sv - tenyr instruction fetch stage: one outstanding read, valid/ready output
module tenyr_fetch
  import tenyr_pkg::*;
#(
  parameter int unsigned       RAM_LATENCY = 1,
  parameter logic [ADDR_W-1:0] RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              insn_valid,
  input  logic              insn_ready,
  output logic [DATA_W-1:0] insn,
  output logic [ADDR_W-1:0] insn_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  // The counter is loaded on entry to WAIT so that it reads zero on the edge
  // at which memory data becomes valid.
  localparam logic [3:0] LAT_LOAD = 4'(RAM_LATENCY - 1);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic              mem_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              insn_valid_q;
  logic [DATA_W-1:0] insn_q;
  logic [ADDR_W-1:0] insn_pc_q;

  logic       cnt_load;
  logic       cnt_dec;
  logic [3:0] cnt_load_val;
  logic       cnt_zero;

  // A redirect clears the counter so a dropped request leaves no stale count.
  always_comb begin
    cnt_load     = redirect_valid || (state_q == FETCH);
    cnt_load_val = redirect_valid ? 4'd0 : LAT_LOAD;
    cnt_dec      = (state_q == WAIT);
  end

  tenyr_lat_cnt u_lat_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (cnt_load_val),
    .zero_o     (cnt_zero)
  );

  // Fetch FSM with registered memory and instruction outputs; reset beats redirect.
  always_ff @(negedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      fetch_pc_q   <= RESET_PC;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= RESET_PC;
      insn_valid_q <= 1'b0;
      insn_q       <= '0;
      insn_pc_q    <= '0;
    end else if (redirect_valid) begin
      state_q      <= FETCH;
      fetch_pc_q   <= redirect_pc;
      mem_en_q     <= 1'b0;
      insn_valid_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          mem_en_q   <= 1'b1;
          mem_addr_q <= fetch_pc_q;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (cnt_zero) begin
            insn_q       <= mem_data;
            insn_pc_q    <= fetch_pc_q;
            insn_valid_q <= 1'b1;
            mem_en_q     <= 1'b0;
            state_q      <= HOLD;
          end
        end
        HOLD: begin
          if (insn_valid_q && insn_ready) begin
            fetch_pc_q   <= pc_inc(fetch_pc_q);
            insn_valid_q <= 1'b0;
            state_q      <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_rw     = 1'b0;
  assign mem_addr   = mem_addr_q;
  assign insn_valid = insn_valid_q;
  assign insn       = insn_q;
  assign insn_pc    = insn_pc_q;

endmodule

// File: tb/tb_tenyr_fetch.sv
// tb/tb_tenyr_fetch.sv - scoreboard bench for tenyr_fetch at latency 1 and latency 3
module tb_tenyr_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;
  always @(negedge clk) edge_n++;

  // DUT A: latency 1, reset PC 0
  logic        rst_a = 1'b1, ready_a = 1'b0, redir_a = 1'b0;
  logic [23:0] redir_pc_a = '0;
  logic        en_a, rw_a, valid_a;
  logic [23:0] addr_a, pc_a;
  logic [31:0] mdata_a = 32'hDEAD_BEEF, insn_a;

  // DUT B: latency 3, reset PC 0x100
  logic        rst_b = 1'b1, ready_b = 1'b1, redir_b = 1'b0;
  logic [23:0] redir_pc_b = '0;
  logic        en_b, rw_b, valid_b;
  logic [23:0] addr_b, pc_b;
  logic [31:0] mdata_b = 32'hDEAD_BEEF, insn_b;

  tenyr_fetch #(.RAM_LATENCY(1)) dut_a (
    .clk(clk), .reset(rst_a), .mem_en(en_a), .mem_rw(rw_a), .mem_addr(addr_a),
    .mem_data(mdata_a), .insn_valid(valid_a), .insn_ready(ready_a), .insn(insn_a),
    .insn_pc(pc_a), .redirect_valid(redir_a), .redirect_pc(redir_pc_a)
  );

  tenyr_fetch #(.RAM_LATENCY(3), .RESET_PC(24'h000100)) dut_b (
    .clk(clk), .reset(rst_b), .mem_en(en_b), .mem_rw(rw_b), .mem_addr(addr_b),
    .mem_data(mdata_b), .insn_valid(valid_b), .insn_ready(ready_b), .insn(insn_b),
    .insn_pc(pc_b), .redirect_valid(redir_b), .redirect_pc(redir_pc_b)
  );

  function automatic logic [31:0] memf(input logic [23:0] a);
    if (a == 24'h0) return 32'h1234_5678;
    return {a[7:0] ^ 8'h5A, a};
  endfunction

  // Memory models: data is only correct once the address has been held for the full latency.
  int age_a = 0, age_b = 0;
  logic pen_a = 1'b0, pen_b = 1'b0;
  logic [23:0] plast_a = '0, plast_b = '0;
  always @(posedge clk) begin
    if (en_a && pen_a && addr_a == plast_a) begin
      if (age_a < 15) age_a++;
    end else age_a = en_a ? 1 : 0;
    pen_a = en_a; plast_a = addr_a;
    mdata_a = (en_a && age_a >= 1) ? memf(addr_a) : 32'hDEAD_BEEF;
    if (en_b && pen_b && addr_b == plast_b) begin
      if (age_b < 15) age_b++;
    end else age_b = en_b ? 1 : 0;
    pen_b = en_b; plast_b = addr_b;
    mdata_b = (en_b && age_b >= 3) ? memf(addr_b) : 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard for DUT A: expected {pc, insn} pushed by stimulus, popped on each accept.
  logic [55:0] exp_q[$];
  always @(posedge clk) begin
    if (valid_a && ready_a) begin
      if (exp_q.size() == 0) check("unexpected_insn", {pc_a, insn_a}, 56'h0);
      else check("scoreboard_insn", {pc_a, insn_a}, exp_q.pop_front());
    end
  end

  task automatic push(input logic [23:0] a);
    exp_q.push_back({a, memf(a)});
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_valid(input bit which, output int edges);
    int start;
    bit ok;
    start = edge_n;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if ((which ? valid_b : valid_a) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    edges = edge_n - start;
    check(which ? "timeout_b" : "timeout_a", {63'd0, ok}, 64'd1);
  endtask

  task automatic accept_a(input bit redir, input logic [23:0] rpc);
    ready_a = 1'b1; redir_a = redir; redir_pc_a = rpc;
    step();
    ready_a = 1'b0; redir_a = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    for (int i = 0; i < 3; i++) step();
    check("reset_mem_en", {63'd0, en_a}, 64'd0);
    check("reset_mem_addr", {40'd0, addr_a}, 64'd0);
    check("reset_valid", {63'd0, valid_a}, 64'd0);
    check("reset_insn", {32'd0, insn_a}, 64'd0);
    check("reset_insn_pc", {40'd0, pc_a}, 64'd0);
    check("mem_rw", {62'd0, rw_a, rw_b}, 64'd0);
    check("reset_b_mem_addr", {40'd0, addr_b}, 64'h100);

    // First fetch and back-to-back throughput at latency 1.
    push(24'h0); push(24'h1);
    ready_a = 1'b1; rst_a = 1'b0;
    wait_valid(0, lat);
    check("first_latency", lat, 64'd2);
    wait_valid(0, lat);
    check("throughput_gap", lat, 64'd3);
    ready_a = 1'b0;

    // Stall in HOLD: outputs frozen, no memory request.
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_stable", {valid_a, en_a, pc_a, insn_a}, {1'b1, 1'b0, 24'h1, memf(24'h1)});
    end

    // Redirect while the request for PC 2 is in WAIT.
    accept_a(1'b0, 24'h0);
    step();
    check("wait_request", {39'd0, en_a, addr_a}, {39'd0, 1'b1, 24'h2});
    redir_a = 1'b1; redir_pc_a = 24'h000ABC;
    step();
    redir_a = 1'b0;
    check("redirect_kills_valid", {62'd0, valid_a, en_a}, 64'd0);
    push(24'h000ABC);
    wait_valid(0, lat);
    check("redirect_latency", lat, 64'd2);

    // Accept together with redirect: redirect PC wins, no +1.
    accept_a(1'b1, 24'h000005);
    push(24'h000005);
    wait_valid(0, lat);
    accept_a(1'b1, 24'h000010);
    push(24'h000010);
    wait_valid(0, lat);
    check("redirect_on_accept_pc", {40'd0, pc_a}, 64'h10);

    // Wrap from FFFFFF to 000000.
    accept_a(1'b1, 24'hFFFFFF);
    push(24'hFFFFFF);
    wait_valid(0, lat);
    accept_a(1'b0, 24'h0);
    push(24'h000000);
    wait_valid(0, lat);
    check("wrap_pc", {40'd0, pc_a}, 64'h0);
    accept_a(1'b0, 24'h0);
    check("scoreboard_drained", exp_q.size(), 64'd0);

    // Latency 3 device: first fetch, throughput, reset in the middle of WAIT.
    rst_b = 1'b0;
    wait_valid(1, lat);
    check("b_first_latency", lat, 64'd4);
    check("b_first_insn", {pc_b, insn_b}, {8'd0, 24'h100, memf(24'h100)});
    wait_valid(1, lat);
    check("b_throughput_gap", lat, 64'd5);
    check("b_second_insn", {pc_b, insn_b}, {8'd0, 24'h101, memf(24'h101)});
    step(); step(); step();
    check("b_mid_wait", {39'd0, en_b, addr_b}, {39'd0, 1'b1, 24'h102});
    rst_b = 1'b1;
    step();
    check("b_reset_outputs", {en_b, valid_b, addr_b, pc_b}, {1'b0, 1'b0, 24'h100, 24'h0});
    check("b_reset_insn", {32'd0, insn_b}, 64'd0);
    rst_b = 1'b0;
    wait_valid(1, lat);
    check("b_post_reset_latency", lat, 64'd4);
    check("b_post_reset_insn", {pc_b, insn_b}, {8'd0, 24'h100, memf(24'h100)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
